half_adder_design: RTL and testbench

Bit-parallel half adder with a registered output stage, valid qualifier and saturating usage counters. Each lane i produces sum[i] = a[i] XOR b[i] and carry[i] = a[i] AND b[i]. The block is a leaf arithmetic primitive that ripple or carry-save adder trees instantiate. Counters expose operation and carry statistics to a status register.

---
 rtl/half_adder_design_if.sv | 26 ++
 rtl/half_adder_design.sv | 80 ++++++++
 tb/tb_half_adder_design.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/half_adder_design_if.sv
// Bus bundle for half_adder_design: operands, qualifiers, results and usage counters.
// The master modport drives operands; the slave modport is the adder itself.
interface half_adder_design_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             cnt_clr;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
    logic             out_valid;
    logic [CNT_W-1:0] op_count;
    logic [CNT_W-1:0] carry_count;

    modport master (
        output a, b, in_valid, cnt_clr,
        input  sum, carry, out_valid, op_count, carry_count
    );

    modport slave (
        input  a, b, in_valid, cnt_clr,
        output sum, carry, out_valid, op_count, carry_count
    );
endinterface

// File: rtl/half_adder_design.sv
// Bit-parallel half adder (independent lanes) with optional output register stage
// and saturating operation / carry-event counters.
module half_adder_design #(
    parameter int WIDTH      = 1,
    parameter int CNT_W      = 16,
    parameter int REGISTERED = 1
) (
    input logic               clk,
    input logic               rst_n,
    half_adder_design_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;
    logic             w_accept;
    logic             w_any_carry;

    assign w_sum       = bus.a ^ bus.b;
    assign w_carry     = bus.a & bus.b;
    assign w_accept    = bus.in_valid;
    assign w_any_carry = |w_carry;

    generate
        if (REGISTERED != 0) begin : g_reg
            logic [WIDTH-1:0] r_sum;
            logic [WIDTH-1:0] r_carry;
            logic             r_out_valid;

            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum       <= '0;
                    r_carry     <= '0;
                    r_out_valid <= 1'b0;
                end else begin
                    r_out_valid <= w_accept;
                    if (w_accept) begin
                        r_sum   <= w_sum;
                        r_carry <= w_carry;
                    end
                end
            end

            assign bus.sum       = r_sum;
            assign bus.carry     = r_carry;
            assign bus.out_valid = r_out_valid;
        end else begin : g_comb
            // Reset still forces the outputs low so both build options look alike in reset.
            assign bus.sum       = rst_n ? w_sum   : '0;
            assign bus.carry     = rst_n ? w_carry : '0;
            assign bus.out_valid = rst_n & bus.in_valid;
        end
    endgenerate

    logic [CNT_W-1:0] r_op_count;
    logic [CNT_W-1:0] r_carry_count;

    // Clear beats increment; idle cycles never look at a/b, so X there is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count    <= '0;
            r_carry_count <= '0;
        end else if (bus.cnt_clr) begin
            r_op_count    <= '0;
            r_carry_count <= '0;
        end else if (w_accept) begin
            if (r_op_count != CNT_MAX) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
            if (w_any_carry && (r_carry_count != CNT_MAX)) begin
                r_carry_count <= r_carry_count + CNT_W'(1);
            end
        end
    end

    assign bus.op_count    = r_op_count;
    assign bus.carry_count = r_carry_count;
endmodule

// File: tb/tb_half_adder_design.sv
// Directed bench for half_adder_design: three instances cover 1-bit, 8-bit/4-bit-counter
// registered, and 4-bit combinational builds.
module tb_half_adder_design;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    half_adder_design_if #(.WIDTH(1), .CNT_W(16)) if_w1 ();
    half_adder_design_if #(.WIDTH(8), .CNT_W(4))  if_w8 ();
    half_adder_design_if #(.WIDTH(4), .CNT_W(16)) if_c  ();

    half_adder_design #(.WIDTH(1), .CNT_W(16), .REGISTERED(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .bus(if_w1)
    );
    half_adder_design #(.WIDTH(8), .CNT_W(4), .REGISTERED(1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .bus(if_w8)
    );
    half_adder_design #(.WIDTH(4), .CNT_W(16), .REGISTERED(0)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c)
    );

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chk_w8(input string name, input logic [7:0] s, input logic [7:0] c,
                          input logic v, input logic [3:0] op, input logic [3:0] cc);
        chk({name, ".sum"},   32'(if_w8.sum),         32'(s));
        chk({name, ".carry"}, 32'(if_w8.carry),       32'(c));
        chk({name, ".valid"}, 32'(if_w8.out_valid),   32'(v));
        chk({name, ".op"},    32'(if_w8.op_count),    32'(op));
        chk({name, ".cc"},    32'(if_w8.carry_count), 32'(cc));
    endtask

    task automatic test_reset();
        repeat (2) tick();
        chk("rst.w1.sum",   32'(if_w1.sum),       32'd0);
        chk("rst.w1.carry", 32'(if_w1.carry),     32'd0);
        chk("rst.w1.valid", 32'(if_w1.out_valid), 32'd0);
        chk("rst.w1.op",    32'(if_w1.op_count),  32'd0);
        chk_w8("rst.w8", 8'h00, 8'h00, 1'b0, 4'd0, 4'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_truth_1bit();
        logic [1:0] exp_sc [4];
        exp_sc[0] = 2'b00; exp_sc[1] = 2'b10; exp_sc[2] = 2'b10; exp_sc[3] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            if_w1.a = 1'(i >> 1);
            if_w1.b = 1'(i);
            if_w1.in_valid = 1'b1;
            tick();
            chk($sformatf("tt%0d.sc", i), 32'({if_w1.sum, if_w1.carry}), 32'(exp_sc[i]));
            chk($sformatf("tt%0d.valid", i), 32'(if_w1.out_valid), 32'd1);
        end
        if_w1.in_valid = 1'b0;
        tick();
        chk("tt.valid_drop", 32'(if_w1.out_valid), 32'd0);
        chk("tt.op",         32'(if_w1.op_count),    32'd4);
        chk("tt.cc",         32'(if_w1.carry_count), 32'd1);
    endtask

    task automatic test_multilane();
        if_w8.a = 8'hF0; if_w8.b = 8'hCC; if_w8.in_valid = 1'b1;
        tick();
        chk_w8("ml.acc", 8'h3C, 8'hC0, 1'b1, 4'd1, 4'd1);
        if_w8.a = 8'hFF; if_w8.b = 8'hFF; if_w8.in_valid = 1'b0;
        tick();
        chk_w8("ml.hold", 8'h3C, 8'hC0, 1'b0, 4'd1, 4'd1);
    endtask

    task automatic test_comb();
        if_c.a = 4'hA; if_c.b = 4'h6; if_c.in_valid = 1'b0;
        #1;
        chk("cb.sum",   32'(if_c.sum),   32'hC);
        chk("cb.carry", 32'(if_c.carry), 32'h2);
        chk("cb.v0",    32'(if_c.out_valid), 32'd0);
        if_c.in_valid = 1'b1;
        #1;
        chk("cb.v1",    32'(if_c.out_valid), 32'd1);
        if_c.a = 4'hF; if_c.b = 4'h5;
        #1;
        chk("cb.sum2",   32'(if_c.sum),   32'hA);
        chk("cb.carry2", 32'(if_c.carry), 32'h5);
        if_c.in_valid = 1'b0;
        #1;
        chk("cb.v2",    32'(if_c.out_valid), 32'd0);
    endtask

    task automatic test_saturation();
        if_w8.cnt_clr = 1'b1;
        tick();
        if_w8.cnt_clr = 1'b0;
        chk("sat.clr.op", 32'(if_w8.op_count), 32'd0);
        if_w8.a = 8'h01; if_w8.b = 8'h01; if_w8.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) begin
                chk("sat.14.op", 32'(if_w8.op_count),    32'd14);
                chk("sat.14.cc", 32'(if_w8.carry_count), 32'd14);
            end
        end
        chk("sat.op", 32'(if_w8.op_count),    32'd15);
        chk("sat.cc", 32'(if_w8.carry_count), 32'd15);
        if_w8.cnt_clr = 1'b1;
        tick();
        if_w8.cnt_clr = 1'b0;
        chk("sat.clrpri.op", 32'(if_w8.op_count),    32'd0);
        chk("sat.clrpri.cc", 32'(if_w8.carry_count), 32'd0);
        tick();
        chk_w8("sat.post1", 8'h00, 8'h01, 1'b1, 4'd1, 4'd1);
        if_w8.a = 8'hF0; if_w8.b = 8'h0F;
        tick();
        chk_w8("sat.post2", 8'hFF, 8'h00, 1'b1, 4'd2, 4'd1);
    endtask

    task automatic test_idle();
        if_w8.a = 8'hFF; if_w8.b = 8'hFF; if_w8.in_valid = 1'b0;
        repeat (10) tick();
        chk_w8("idle", 8'hFF, 8'h00, 1'b0, 4'd2, 4'd1);
        if_w8.a = 'x; if_w8.b = 'x;
        repeat (2) tick();
        chk_w8("idle.x", 8'hFF, 8'h00, 1'b0, 4'd2, 4'd1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] es [3];
        logic [7:0] ec [3];
        logic [3:0] ecc [3];
        va[0] = 8'hAA; vb[0] = 8'h55; es[0] = 8'hFF; ec[0] = 8'h00; ecc[0] = 4'd1;
        va[1] = 8'hFF; vb[1] = 8'h01; es[1] = 8'hFE; ec[1] = 8'h01; ecc[1] = 4'd2;
        va[2] = 8'h0F; vb[2] = 8'h0F; es[2] = 8'h00; ec[2] = 8'h0F; ecc[2] = 4'd3;
        if_w8.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_w8.a = va[i]; if_w8.b = vb[i];
            tick();
            chk_w8($sformatf("b2b%0d", i), es[i], ec[i], 1'b1, 4'(3 + i), ecc[i]);
        end
    endtask

    task automatic test_async_reset();
        // w8 still has in_valid=1 from the burst: out_valid=1, counters nonzero.
        if_w8.a = 8'h03; if_w8.b = 8'h01;
        tick();
        chk_w8("ar.pre", 8'h02, 8'h01, 1'b1, 4'd6, 4'd4);
        if_w8.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_w8("ar.async", 8'h00, 8'h00, 1'b0, 4'd0, 4'd0);
        chk("ar.w1.op", 32'(if_w1.op_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_w8("ar.release", 8'h00, 8'h00, 1'b0, 4'd0, 4'd0);
        tick();
        chk("ar.release2.valid", 32'(if_w8.out_valid), 32'd0);
    endtask

    initial begin
        if_w1.a = '0; if_w1.b = '0; if_w1.in_valid = 1'b0; if_w1.cnt_clr = 1'b0;
        if_w8.a = '0; if_w8.b = '0; if_w8.in_valid = 1'b0; if_w8.cnt_clr = 1'b0;
        if_c.a  = '0; if_c.b  = '0; if_c.in_valid  = 1'b0; if_c.cnt_clr  = 1'b0;
        test_reset();
        tick();
        test_truth_1bit();
        test_multilane();
        test_comb();
        test_saturation();
        test_idle();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
